// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults for the porch-insertion stage, plus helpers that
// derive the sync-pulse window from active size, porches and total size.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_TOTAL_COLS    = 800;
  localparam int DEF_TOTAL_ROWS    = 525;
  localparam int DEF_ACTIVE_COLS   = 640;
  localparam int DEF_ACTIVE_ROWS   = 480;
  localparam int DEF_FRONT_PORCH_H = 18;
  localparam int DEF_BACK_PORCH_H  = 50;
  localparam int DEF_FRONT_PORCH_V = 10;
  localparam int DEF_BACK_PORCH_V  = 33;
  localparam int DEF_VIDEO_WIDTH   = 3;

  // First and last counter value (inclusive) of the active-low sync pulse.
  function automatic int sync_start(input int active, input int front_porch);
    return active + front_porch;
  endfunction

  function automatic int sync_end(input int total, input int back_porch);
    return total - back_porch - 1;
  endfunction

  localparam int HS_START = sync_start(DEF_ACTIVE_COLS, DEF_FRONT_PORCH_H);
  localparam int HS_END   = sync_end(DEF_TOTAL_COLS, DEF_BACK_PORCH_H);
  localparam int VS_START = sync_start(DEF_ACTIVE_ROWS, DEF_FRONT_PORCH_V);
  localparam int VS_END   = sync_end(DEF_TOTAL_ROWS, DEF_BACK_PORCH_V);

endpackage

// File: rtl/sync_to_count.sv
// Recovers col/row of the stage-1 sample from the active-video frame flag:
// rising-edge detect, wrapping counters, lock flag and unexpected-restart pulse.
module sync_to_count
  import vga_timing_pkg::*;
#(
  parameter int TOTAL_COLS = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS = DEF_TOTAL_ROWS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vsync_i,
  input  logic             vsync_prev_i,
  output logic [CNT_W-1:0] col_o,
  output logic [CNT_W-1:0] row_o,
  output logic             locked_o,
  output logic             resync_o
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(TOTAL_COLS - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(TOTAL_ROWS - 1);

  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic             locked_q, locked_d;
  logic             resync_q, resync_d;
  logic             frame_start;
  logic             at_last;

  assign frame_start = vsync_i & ~vsync_prev_i;
  assign at_last     = (col_q == COL_LAST) && (row_q == ROW_LAST);

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    locked_d = locked_q;
    resync_d = 1'b0;
    if (frame_start) begin
      // A start landing where the wrap would go anyway is the normal case.
      col_d    = '0;
      row_d    = '0;
      locked_d = 1'b1;
      resync_d = locked_q & ~at_last;
    end else if (col_q == COL_LAST) begin
      col_d = '0;
      row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end else begin
      col_d = col_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q    <= '0;
      row_q    <= '0;
      locked_q <= 1'b0;
      resync_q <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      locked_q <= locked_d;
      resync_q <= resync_d;
    end
  end

  assign col_o    = col_q;
  assign row_o    = row_q;
  assign locked_o = locked_q;
  assign resync_o = resync_q;

endmodule

// File: rtl/vga_porch_insert.sv
// Final video stage: turns active-video flags into standard active-low VGA
// syncs with porches and blanks RGB outside the visible area. Latency 2 clk.
module vga_porch_insert
  import vga_timing_pkg::*;
#(
  parameter int TOTAL_COLS    = DEF_TOTAL_COLS,
  parameter int TOTAL_ROWS    = DEF_TOTAL_ROWS,
  parameter int ACTIVE_COLS   = DEF_ACTIVE_COLS,
  parameter int ACTIVE_ROWS   = DEF_ACTIVE_ROWS,
  parameter int FRONT_PORCH_H = DEF_FRONT_PORCH_H,
  parameter int BACK_PORCH_H  = DEF_BACK_PORCH_H,
  parameter int FRONT_PORCH_V = DEF_FRONT_PORCH_V,
  parameter int BACK_PORCH_V  = DEF_BACK_PORCH_V,
  parameter int VIDEO_WIDTH   = DEF_VIDEO_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_hsync,
  input  logic                   i_vsync,
  input  logic [VIDEO_WIDTH-1:0] i_vga_r,
  input  logic [VIDEO_WIDTH-1:0] i_vga_g,
  input  logic [VIDEO_WIDTH-1:0] i_vga_b,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic [VIDEO_WIDTH-1:0] o_vga_r,
  output logic [VIDEO_WIDTH-1:0] o_vga_g,
  output logic [VIDEO_WIDTH-1:0] o_vga_b,
  output logic                   o_locked,
  output logic                   o_resync
);

  localparam logic [CNT_W-1:0] HS_START_C = CNT_W'(sync_start(ACTIVE_COLS, FRONT_PORCH_H));
  localparam logic [CNT_W-1:0] HS_END_C   = CNT_W'(sync_end(TOTAL_COLS, BACK_PORCH_H));
  localparam logic [CNT_W-1:0] VS_START_C = CNT_W'(sync_start(ACTIVE_ROWS, FRONT_PORCH_V));
  localparam logic [CNT_W-1:0] VS_END_C   = CNT_W'(sync_end(TOTAL_ROWS, BACK_PORCH_V));
  localparam logic [CNT_W-1:0] ACT_COLS_C = CNT_W'(ACTIVE_COLS);
  localparam logic [CNT_W-1:0] ACT_ROWS_C = CNT_W'(ACTIVE_ROWS);

  // Stage 1: input capture.
  logic                   r1_hsync_q;
  logic                   r1_vsync_q;
  logic [VIDEO_WIDTH-1:0] r1_r_q, r1_g_q, r1_b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_hsync_q <= 1'b0;
      r1_vsync_q <= 1'b0;
      r1_r_q     <= '0;
      r1_g_q     <= '0;
      r1_b_q     <= '0;
    end else begin
      r1_hsync_q <= i_hsync;
      r1_vsync_q <= i_vsync;
      r1_r_q     <= i_vga_r;
      r1_g_q     <= i_vga_g;
      r1_b_q     <= i_vga_b;
    end
  end

  // The line flag stays aligned with the pixel but blanking trusts the counters.
  logic unused_line_flag;
  assign unused_line_flag = r1_hsync_q;

  logic [CNT_W-1:0] col, row;
  logic             locked;

  sync_to_count #(
    .TOTAL_COLS (TOTAL_COLS),
    .TOTAL_ROWS (TOTAL_ROWS)
  ) u_sync_to_count (
    .clk          (clk),
    .rst          (rst),
    .vsync_i      (i_vsync),
    .vsync_prev_i (r1_vsync_q),
    .col_o        (col),
    .row_o        (row),
    .locked_o     (locked),
    .resync_o     (o_resync)
  );

  // Stage 2: sync regeneration and blanking.
  logic                   hs_low, vs_low, visible;
  logic                   hsync_q, hsync_d;
  logic                   vsync_q, vsync_d;
  logic [VIDEO_WIDTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic                   locked_q;

  always_comb begin
    hs_low  = (col >= HS_START_C) && (col <= HS_END_C);
    vs_low  = (row >= VS_START_C) && (row <= VS_END_C);
    visible = locked && (col < ACT_COLS_C) && (row < ACT_ROWS_C);
    hsync_d = ~(locked & hs_low);
    vsync_d = ~(locked & vs_low);
    r_d     = visible ? r1_r_q : '0;
    g_d     = visible ? r1_g_q : '0;
    b_d     = visible ? r1_b_q : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
      locked_q <= 1'b0;
    end else begin
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      locked_q <= locked;
    end
  end

  assign o_hsync  = hsync_q;
  assign o_vsync  = vsync_q;
  assign o_vga_r  = r_q;
  assign o_vga_g  = g_q;
  assign o_vga_b  = b_q;
  assign o_locked = locked_q;

endmodule
